// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with optional first-word-fall-through reads, programmable
// almost-full / almost-empty thresholds, fill level, sticky error flags and a
// synchronous flush. Port naming matches async_fifo so the two can be swapped.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush (beats winc/rinc)
//   winc, wdata       write request and data; wfull / awfull status
//   afull_th          almost-full threshold (awfull = level >= afull_th)
//   rinc, rdata       read request (pop) and data; rempty / arempty status
//   aempty_th         almost-empty threshold (arempty = level <= aempty_th)
//   level             occupancy 0..2**ASIZE
//   ovf, udf          sticky overflow / underflow, cleared by clear or reset
module sync_fifo_pro #(
  parameter int unsigned DSIZE       = 32,
  parameter int unsigned ASIZE       = 4,
  parameter int unsigned FALLTHROUGH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic [ASIZE:0]   afull_th,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  input  logic [ASIZE:0]   aempty_th,
  output logic [ASIZE:0]   level,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned   Depth     = 2 ** ASIZE;
  localparam logic [ASIZE:0] LevelFull = (ASIZE + 1)'(Depth);

  logic [DSIZE-1:0] mem_q [Depth];
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wacc, racc;

  // Status is decoded from the level register only, so no path exists from
  // winc/rinc to any output.
  always_comb begin
    level   = level_q;
    wfull   = (level_q == LevelFull);
    rempty  = (level_q == '0);
    awfull  = (level_q >= afull_th);
    arempty = (level_q <= aempty_th);
    ovf     = ovf_q;
    udf     = udf_q;
  end

  // Requests are qualified against the pre-edge flags; clear blocks both.
  always_comb begin
    wacc = winc && !wfull && !clear;
    racc = rinc && !rempty && !clear;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wacc) wptr_d = wptr_q + 1'b1;
      if (racc) rptr_d = rptr_q + 1'b1;
      unique case ({wacc, racc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (winc && wfull)  ovf_d = 1'b1;
      if (rinc && rempty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wacc) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end

  if (FALLTHROUGH != 0) begin : g_fwft
    // Head of queue is always presented; meaningless while empty.
    assign rdata = mem_q[rptr_q[ASIZE-1:0]];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (racc) rdata_d = mem_q[rptr_q[ASIZE-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_pro.sv
module tb_sync_fifo_pro;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        winc = 1'b0;
  logic        rinc = 1'b0;
  logic [31:0] wdata = '0;
  logic [4:0]  afull_th = 5'd12;
  logic [4:0]  aempty_th = 5'd2;

  // r = registered-read instance, f = fall-through instance
  logic        wfull_r, awfull_r, rempty_r, arempty_r, ovf_r, udf_r;
  logic        wfull_f, awfull_f, rempty_f, arempty_f, ovf_f, udf_f;
  logic [31:0] rdata_r, rdata_f;
  logic [4:0]  level_r, level_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_pro #(.DSIZE(32), .ASIZE(4), .FALLTHROUGH(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .clear(clear), .winc(winc), .wdata(wdata),
    .wfull(wfull_r), .awfull(awfull_r), .afull_th(afull_th), .rinc(rinc),
    .rdata(rdata_r), .rempty(rempty_r), .arempty(arempty_r), .aempty_th(aempty_th),
    .level(level_r), .ovf(ovf_r), .udf(udf_r)
  );

  sync_fifo_pro #(.DSIZE(32), .ASIZE(4), .FALLTHROUGH(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clear(clear), .winc(winc), .wdata(wdata),
    .wfull(wfull_f), .awfull(awfull_f), .afull_th(afull_th), .rinc(rinc),
    .rdata(rdata_f), .rempty(rempty_f), .arempty(arempty_f), .aempty_th(aempty_th),
    .level(level_f), .ovf(ovf_f), .udf(udf_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus the sticky flags and the last
  // popped word (what registered-read mode shows).
  logic [31:0] mq[$];
  logic        m_ovf, m_udf;
  logic [31:0] m_rdata;

  initial begin
    int n;
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdata = '0;
      end else if (clear) begin
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        n = mq.size();
        if (winc && n == 16) m_ovf = 1'b1;
        if (rinc && n == 0)  m_udf = 1'b1;
        if (rinc && n > 0)   m_rdata = mq.pop_front();
        if (winc && n < 16)  mq.push_back(wdata);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = mq.size();
        chk("level_r", 32'(level_r), 32'(n));
        chk("level_f", 32'(level_f), 32'(n));
        chk("wfull_r", 32'(wfull_r), 32'(n == 16));
        chk("wfull_f", 32'(wfull_f), 32'(n == 16));
        chk("rempty_r", 32'(rempty_r), 32'(n == 0));
        chk("rempty_f", 32'(rempty_f), 32'(n == 0));
        chk("awfull_r", 32'(awfull_r), 32'(n >= int'(afull_th)));
        chk("awfull_f", 32'(awfull_f), 32'(n >= int'(afull_th)));
        chk("arempty_r", 32'(arempty_r), 32'(n <= int'(aempty_th)));
        chk("arempty_f", 32'(arempty_f), 32'(n <= int'(aempty_th)));
        chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
        chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
        chk("udf_r", 32'(udf_r), 32'(m_udf));
        chk("udf_f", 32'(udf_f), 32'(m_udf));
        chk("rdata_r", rdata_r, m_rdata);
        if (n > 0) chk("rdata_f", rdata_f, mq[0]);
      end
    end
  end

  // One clock: inputs held across the next rising edge, then returned idle.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic c);
    winc  = w;
    wdata = d;
    rinc  = r;
    clear = c;
    @(posedge clk);
    #1;
    winc  = 1'b0;
    rinc  = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    // Reset / idle
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    chk("idle_rempty", 32'(rempty_r & rempty_f), 32'd1);
    chk("idle_wfull", 32'(wfull_r | wfull_f), 32'd0);
    chk("idle_level", 32'(level_r | level_f), 32'd0);
    chk("idle_ovf_udf", 32'(ovf_r | udf_r | ovf_f | udf_f), 32'd0);
    chk("idle_rdata_r", rdata_r, 32'd0);

    // Fill to full with threshold crossings, then overflow
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 1)  chk("arempty_at2", 32'(arempty_r & arempty_f), 32'd1);
      if (i == 2)  chk("arempty_at3", 32'(arempty_r | arempty_f), 32'd0);
      if (i == 10) chk("awfull_at11", 32'(awfull_r | awfull_f), 32'd0);
      if (i == 11) chk("awfull_at12", 32'(awfull_r & awfull_f), 32'd1);
    end
    chk("full_level", 32'(level_r), 32'd16);
    chk("full_wfull", 32'(wfull_r & wfull_f), 32'd1);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf_r & ovf_f), 32'd1);
    chk("ovf_level", 32'(level_f), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_fwft", rdata_f, 32'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("drain_reg", rdata_r, 32'(i));
    end
    chk("drained_rempty", 32'(rempty_r & rempty_f), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Read latency in both modes
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    chk("lat_rempty", 32'(rempty_r | rempty_f), 32'd0);
    chk("lat_fwft", rdata_f, 32'hA);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("lat_reg", rdata_r, 32'hA);
    chk("lat_empty", 32'(rempty_r & rempty_f), 32'd1);

    // Threshold change takes effect in the same cycle; read-while-full
    for (int i = 0; i < 13; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    chk("th_awfull13", 32'(awfull_r & awfull_f), 32'd1);
    afull_th = 5'd14;
    #1;
    chk("th_awfull_chg", 32'(awfull_r | awfull_f), 32'd0);
    for (int i = 13; i < 16; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h1FF, 1'b1, 1'b0);
    chk("full_rw_level", 32'(level_r), 32'd15);
    chk("full_rw_rdata", rdata_r, 32'h100);
    cyc(1'b1, 32'h1FE, 1'b0, 1'b0);
    chk("refill_level", 32'(level_f), 32'd16);
    cyc(1'b0, '0, 1'b0, 1'b1);
    afull_th = 5'd12;

    // Continuous write+read across pointer wrap, then underflow
    cyc(1'b1, 32'd200, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 32'd201 + 32'(i), 1'b1, 1'b0);
    chk("stream_level", 32'(level_r), 32'd1);
    chk("stream_rdata", rdata_r, 32'd239);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_last", rdata_r, 32'd240);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("udf_set", 32'(udf_r & udf_f), 32'd1);

    // Flush mid-stream drops a same-cycle write
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b0, 1'b1);
    chk("clr_level", 32'(level_r | level_f), 32'd0);
    chk("clr_flags", 32'(ovf_r | udf_r | ovf_f | udf_f), 32'd0);
    chk("clr_rempty", 32'(rempty_r & rempty_f), 32'd1);
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    chk("post_clr_fwft", rdata_f, 32'h77);

    // Asynchronous reset between edges
    cyc(1'b1, 32'h88, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level_r | level_f), 32'd0);
    chk("arst_rempty", 32'(rempty_r & rempty_f & arempty_r & arempty_f), 32'd1);
    chk("arst_rdata_r", rdata_r, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("after_rst_level", 32'(level_r), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
